// File: rtl/sram_arbiter.sv
// Arbitrates a single-port async SRAM between a display reader and one writer.
// Display reads always win; all SRAM-side outputs are registered.
module sram_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_valid,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic              o_wr_starved,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  output logic [DATA_W-1:0] o_SRAM_DQ,
  output logic              o_SRAM_DQ_OE,
  input  logic [DATA_W-1:0] i_SRAM_DQ,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  // state   | meaning
  // S_IDLE  | no SRAM access this cycle, all strobes inactive
  // S_READ  | display word being read from the SRAM this cycle
  // S_WRITE | writer word being driven into the SRAM this cycle
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] starve_cnt;

  always_comb begin
    state_nxt = S_IDLE;
    if (i_disp_req)
      state_nxt = S_READ;
    else if (i_wr_req)
      state_nxt = S_WRITE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      o_SRAM_ADDR  <= '0;
      o_SRAM_DQ    <= '0;
      o_SRAM_DQ_OE <= 1'b0;
      o_SRAM_CE_N  <= 1'b1;
      o_SRAM_OE_N  <= 1'b1;
      o_SRAM_WE_N  <= 1'b1;
      o_SRAM_LB_N  <= 1'b1;
      o_SRAM_UB_N  <= 1'b1;
      o_disp_data  <= '0;
      o_disp_valid <= 1'b0;
      o_wr_ack     <= 1'b0;
      starve_cnt   <= 8'd0;
      o_wr_starved <= 1'b0;
    end else begin
      state <= state_nxt;

      // Read data is captured at the edge that ends the read cycle.
      o_disp_valid <= (state == S_READ);
      if (state == S_READ)
        o_disp_data <= i_SRAM_DQ;

      o_wr_ack     <= (state_nxt == S_WRITE);
      o_SRAM_DQ_OE <= (state_nxt == S_WRITE);
      o_SRAM_CE_N  <= (state_nxt == S_IDLE);
      o_SRAM_OE_N  <= (state_nxt != S_READ);
      o_SRAM_WE_N  <= (state_nxt != S_WRITE);
      o_SRAM_LB_N  <= (state_nxt == S_IDLE);
      o_SRAM_UB_N  <= (state_nxt == S_IDLE);

      case (state_nxt)
        S_READ:  o_SRAM_ADDR <= i_disp_addr;
        S_WRITE: begin
          o_SRAM_ADDR <= i_wr_addr;
          o_SRAM_DQ   <= i_wr_data;
        end
        default: ;
      endcase

      if (i_wr_req && (state_nxt != S_WRITE)) begin
        if (starve_cnt != 8'hFF)
          starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= 8'd0;
      end

      // Flag follows the counter by one cycle; it never changes the grant.
      o_wr_starved <= (starve_cnt >= STARVE_LIM);
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: a transaction-level reference model with a
// read-return queue and shadow memory predicts every cycle of SRAM/bus activity.
module tb_sram_arbiter;

  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int LIMIT = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_disp_req = 1'b0;
  logic [AW-1:0] i_disp_addr = '0;
  logic [DW-1:0] o_disp_data;
  logic          o_disp_valid;
  logic          i_wr_req = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [DW-1:0] i_wr_data = '0;
  logic          o_wr_ack, o_wr_starved;
  logic [AW-1:0] o_SRAM_ADDR;
  logic [DW-1:0] o_SRAM_DQ;
  logic          o_SRAM_DQ_OE;
  logic [DW-1:0] i_SRAM_DQ = 16'hDEAD;
  logic          o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_disp_req(i_disp_req), .i_disp_addr(i_disp_addr),
    .o_disp_data(o_disp_data), .o_disp_valid(o_disp_valid),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ack(o_wr_ack), .o_wr_starved(o_wr_starved),
    .o_SRAM_ADDR(o_SRAM_ADDR), .o_SRAM_DQ(o_SRAM_DQ), .o_SRAM_DQ_OE(o_SRAM_DQ_OE),
    .i_SRAM_DQ(i_SRAM_DQ),
    .o_SRAM_CE_N(o_SRAM_CE_N), .o_SRAM_OE_N(o_SRAM_OE_N), .o_SRAM_WE_N(o_SRAM_WE_N),
    .o_SRAM_LB_N(o_SRAM_LB_N), .o_SRAM_UB_N(o_SRAM_UB_N)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_ack = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    logic [31:0] t;
    if (i == 16) return 16'hBEEF;
    t = i * 32'd40503;
    return t[15:0] ^ 16'h1234;
  endfunction

  // SRAM device model: 1K words, address aliased on the low 10 bits.
  logic [DW-1:0] sram_mem [1024];
  bit            sram_wr  [1024];

  function automatic logic [DW-1:0] sram_word(input int i);
    return sram_wr[i] ? sram_mem[i] : init_word(i);
  endfunction

  always begin
    @(posedge i_clk);
    if (!o_SRAM_CE_N && !o_SRAM_WE_N && o_SRAM_DQ_OE) begin
      sram_mem[int'(o_SRAM_ADDR[9:0])] = o_SRAM_DQ;
      sram_wr[int'(o_SRAM_ADDR[9:0])]  = 1'b1;
    end
  end

  // Device drives read data mid-cycle while output-enabled, junk otherwise.
  always begin
    @(negedge i_clk);
    if (!o_SRAM_CE_N && !o_SRAM_OE_N)
      i_SRAM_DQ = sram_word(int'(o_SRAM_ADDR[9:0]));
    else
      i_SRAM_DQ = 16'hDEAD;
  end

  // Reference model.
  typedef struct {int due; logic [DW-1:0] data;} rd_t;
  rd_t           rd_q[$];
  logic [DW-1:0] ref_mem [int];
  int            cyc = 0;
  int            m_op = 0;      // 0 idle, 1 read, 2 write
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_dq = '0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_ack = 1'b0;
  int            m_cnt = 0;
  logic          m_starved = 1'b0;

  function automatic logic [DW-1:0] ref_word(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : init_word(i);
  endfunction

  always begin
    @(posedge i_clk);
    cyc++;
    if (i_rst) begin
      m_op = 0; m_addr = '0; m_dq = '0; m_valid = 1'b0; m_data = '0;
      m_ack = 1'b0; m_cnt = 0; m_starved = 1'b0;
      rd_q.delete();
    end else begin
      m_valid = 1'b0;
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        m_valid = 1'b1;
        m_data  = rd_q[0].data;
        void'(rd_q.pop_front());
      end
      m_starved = (m_cnt >= LIMIT);
      if (i_disp_req) begin
        m_op   = 1;
        m_addr = i_disp_addr;
        rd_q.push_back('{cyc + 1, ref_word(int'(i_disp_addr[9:0]))});
      end else if (i_wr_req) begin
        m_op   = 2;
        m_addr = i_wr_addr;
        m_dq   = i_wr_data;
        ref_mem[int'(i_wr_addr[9:0])] = i_wr_data;
      end else begin
        m_op = 0;
      end
      m_ack = (m_op == 2);
      if (i_wr_req && m_op != 2) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      else                       m_cnt = 0;
    end
  end

  function automatic logic [5:0] exp_strb(input int op);
    case (op)
      1:       return 6'b001000;   // ce oe we lb ub dq_oe
      2:       return 6'b010001;
      default: return 6'b111110;
    endcase
  endfunction

  always begin
    @(negedge i_clk);
    if (chk_en) begin
      chk("strobes", 64'({o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N, o_SRAM_DQ_OE}),
          64'(exp_strb(m_op)));
      chk("sram_addr", 64'(o_SRAM_ADDR), 64'(m_addr));
      chk("sram_dq", 64'(o_SRAM_DQ), 64'(m_dq));
      chk("disp_valid", 64'(o_disp_valid), 64'(m_valid));
      chk("disp_data", 64'(o_disp_data), 64'(m_data));
      chk("wr_ack", 64'(o_wr_ack), 64'(m_ack));
      chk("wr_starved", 64'(o_wr_starved), 64'(m_starved));
      chk("oe_contention", 64'(o_SRAM_DQ_OE & ~o_SRAM_OE_N), 64'(0));
      n_valid += int'(o_disp_valid);
      n_ack   += int'(o_wr_ack);
    end
  end

  // Writer: holds its head request until acked, then advances.
  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  wr_t wq[$];

  task automatic tick(input logic rst, input logic dreq, input logic [AW-1:0] daddr);
    @(negedge i_clk);
    if (o_wr_ack && wq.size() > 0) void'(wq.pop_front());
    i_rst       = rst;
    i_disp_req  = dreq;
    i_disp_addr = daddr;
    i_wr_req    = (wq.size() > 0);
    if (wq.size() > 0) begin
      i_wr_addr = wq[0].addr;
      i_wr_data = wq[0].data;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, '0);
  endtask

  initial begin
    int v0, a0, nbad_mem, prob;

    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, '0);
    chk_en = 1'b1;
    tick(1'b1, 1'b0, '0);
    idle(2);

    // Single read of the known 0xBEEF word.
    tick(1'b0, 1'b1, 20'h00010);
    tick(1'b0, 1'b0, '0);
    chk("single_rd_oe", 64'(o_SRAM_OE_N), 64'(0));
    chk("single_rd_addr", 64'(o_SRAM_ADDR), 64'h00010);
    tick(1'b0, 1'b0, '0);
    chk("single_rd_valid", 64'(o_disp_valid), 64'(1));
    chk("single_rd_data", 64'(o_disp_data), 64'hBEEF);
    idle(3);

    // Long display burst.
    v0 = n_valid; a0 = n_ack;
    for (int i = 0; i < 640; i++) tick(1'b0, 1'b1, AW'(i));
    idle(4);
    chk("burst_valids", 64'(n_valid - v0), 64'(640));
    chk("burst_acks", 64'(n_ack - a0), 64'(0));

    // Writer blocked by a 10-cycle burst, then a saturating 300-cycle burst.
    wq.push_back('{20'h12345, 16'hA5A5});
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, AW'($urandom_range(0, 1023)));
    idle(4);
    wq.push_back('{20'h00345, 16'h5A5A});
    for (int i = 0; i < 300; i++) tick(1'b0, 1'b1, AW'($urandom_range(0, 1023)));
    idle(4);

    // Back-to-back write stream with display idle.
    a0 = n_ack;
    for (int i = 0; i < 4; i++) wq.push_back('{AW'(20'h00100 + i), DW'(16'hC000 + i)});
    idle(8);
    chk("wstream_acks", 64'(n_ack - a0), 64'(4));
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, AW'(20'h00100 + i));
    idle(4);

    // Read/write/read turnaround.
    for (int r = 0; r < 5; r++) begin
      wq.push_back('{AW'($urandom), DW'($urandom)});
      tick(1'b0, 1'b1, AW'($urandom));
      tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b1, AW'($urandom));
    end
    idle(4);

    // Reset asserted during the read cycle, with a write pending.
    wq.push_back('{20'h00077, 16'h7777});
    tick(1'b0, 1'b1, 20'h00055);
    tick(1'b1, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("rst_mid_valid", 64'(o_disp_valid), 64'(0));
    idle(4);

    // Randomized traffic with bursty display load and rare resets.
    prob = 40;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) prob = ($urandom_range(0, 2) == 0) ? 95 : int'($urandom_range(10, 70));
      if (wq.size() < 2 && $urandom_range(0, 3) == 0)
        wq.push_back('{AW'($urandom), DW'($urandom)});
      tick(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) < prob),
           AW'($urandom));
    end
    idle(12);

    nbad_mem = 0;
    for (int i = 0; i < 1024; i++)
      if (sram_word(i) !== ref_word(i)) nbad_mem++;
    chk("mem_contents", 64'(nbad_mem), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 Parameter DATA_W, default 16, SRAM word width.
REQ-003 Parameter STARVE_LIMIT, default 8, writer-wait cycles before o_wr_starved asserts.
REQ-004 i_clk  in  1  single clock, all logic on rising edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_disp_req  in  1  display read request, one word per asserted cycle.
REQ-007 i_disp_addr  in  ADDR_W  display read address.
REQ-008 o_disp_data  out  DATA_W  read data returned to display.
REQ-009 o_disp_valid  out  1  o_disp_data valid this cycle.
REQ-010 i_wr_req  in  1  writer request, held until acked.
REQ-011 i_wr_addr  in  ADDR_W  write address.
REQ-012 i_wr_data  in  DATA_W  write data.
REQ-013 o_wr_ack  out  1  one-cycle pulse, write performed this cycle.
REQ-014 o_wr_starved  out  1  writer waiting >= STARVE_LIMIT cycles.
REQ-015 o_SRAM_ADDR  out  ADDR_W  SRAM address.
REQ-016 o_SRAM_DQ  out  DATA_W  SRAM write data.
REQ-017 o_SRAM_DQ_OE  out  1  DQ output enable (top level builds the tristate).
REQ-018 i_SRAM_DQ  in  DATA_W  SRAM read data.
REQ-019 o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  active-low SRAM strobes.

Function
REQ-020 FSM states: S_IDLE, S_READ, S_WRITE; state = operation on SRAM bus this cycle; every SRAM output registered.
REQ-021 Arbitration at each edge: i_disp_req -> S_READ; else i_wr_req -> S_WRITE; else S_IDLE.
REQ-022 Display has absolute priority; simultaneous requests -> display wins, writer waits.
REQ-023 S_READ: o_SRAM_ADDR = sampled i_disp_addr, CE_N=0, OE_N=0, WE_N=1, LB_N=UB_N=0, DQ_OE=0.
REQ-024 S_WRITE: o_SRAM_ADDR = i_wr_addr, o_SRAM_DQ = i_wr_data, CE_N=0, OE_N=1, WE_N=0, LB_N=UB_N=0, DQ_OE=1, o_wr_ack=1.
REQ-025 S_IDLE: CE_N=OE_N=WE_N=LB_N=UB_N=1, DQ_OE=0, address holds last value.
REQ-026 Read latency 2: request sampled edge N -> S_READ during cycle N+1 -> i_SRAM_DQ registered into o_disp_data with o_disp_valid=1 during cycle N+2.
REQ-027 Back-to-back reads: one word per cycle, no bubbles, o_disp_valid contiguous, order preserved.
REQ-028 o_disp_data holds last value when o_disp_valid=0.
REQ-029 Write latency: o_wr_ack asserts in the cycle after the edge sampling the winning i_wr_req; writer drops or advances request on the edge ending the ack cycle.
REQ-030 Writer re-asserting with the same or a new address immediately after ack -> next write granted with no idle cycle if display idle.
REQ-031 Turnaround: S_WRITE -> S_READ requires no idle cycle (DQ_OE deasserts same edge OE_N asserts); S_READ -> S_WRITE likewise.
REQ-032 Starvation counter: 8-bit, saturating at 255; increments each cycle i_wr_req=1 and not granted; clears on grant or i_wr_req=0.
REQ-033 o_wr_starved = (counter >= STARVE_LIMIT), registered; informational only, does not alter priority.
REQ-034 Request inputs sampled only at edges; combinational glitches between edges ignored.

Reset
REQ-035 While i_rst=1 at an edge: state S_IDLE, all strobes 1, DQ_OE=0, o_SRAM_ADDR=0, o_SRAM_DQ=0, o_disp_data=0, o_disp_valid=0, o_wr_ack=0, counter=0, o_wr_starved=0.
REQ-036 Reset mid-transaction aborts it: in-flight read returns no o_disp_valid, pending write never acked; first grant possible at edge after i_rst falls.

Verification
REQ-037 Single read: i_disp_req=1 addr 0x00010 one cycle, SRAM model returns 0xBEEF -> cycle+1 OE_N=0 addr 0x00010, cycle+2 o_disp_valid=1 data 0xBEEF.
REQ-038 Burst: 640 consecutive reads addr 0..639 -> 640 contiguous valids, data in address order, no write grants.
REQ-039 Conflict: i_wr_req held (addr 0x12345, data 0xA5A5) during 10-cycle display burst -> no ack during burst, o_wr_starved=1 from wait cycle 8, ack with WE_N=0 DQ_OE=1 in first cycle after burst, starved clears next cycle.
REQ-040 Write stream: display idle, 4 writes back-to-back -> 4 consecutive ack pulses, correct addr/data each cycle, model contents match.
REQ-041 Turnaround: alternating read/write/read -> DQ_OE=1 only in write cycle, never with OE_N=0.
REQ-042 Reset mid-read: i_rst=1 in the S_READ cycle -> no o_disp_valid, all outputs at reset values next cycle.
